// File: rtl/dlatch.sv
// Level-sensitive D latch with asynchronous active-low clear.
// The latch is transparent while clk is high and holds while clk is low.
// q_bar is derived from the single stored value, so it is always the exact
// complement of q, including during reset.
module dlatch #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] q_q;

  // Storage: clear dominates the enable; follow d while clk is high, hold otherwise.
  always_latch begin
    if (!reset_n) begin
      q_q <= '0;
    end else if (clk) begin
      q_q <= d;
    end
  end

  // Outputs come straight from the storage node.
  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: tb/tb_dlatch.sv
// Directed bench for dlatch: a WIDTH=1 and a WIDTH=8 instance share clk and reset_n.
// A sampled behavioural model is checked against both instances every nanosecond,
// and hand-computed literal expectations are checked at chosen points.
module tb_dlatch;
  timeunit 1ns;
  timeprecision 100ps;

  logic       clk;
  logic       reset_n;
  logic       d1;
  logic       q1;
  logic       qb1;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [7:0] qb8;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  dlatch #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d1),
    .q       (q1),
    .q_bar   (qb1)
  );

  dlatch #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d8),
    .q       (q8),
    .q_bar   (qb8)
  );

  // 10 ns clock: low 0-5, high 5-10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $realtime);
    end
  endtask

  task automatic wait_until(input real t);
    if (t > $realtime) #(t - $realtime);
  endtask

  // Model: inputs only change on whole nanoseconds, so sampling at every
  // half-nanosecond sees each stable input combination. The stored value is
  // cleared under reset, copied from d while the enable is high, and otherwise
  // keeps what it had at the previous sample.
  logic       m_q1;
  logic [7:0] m_q8;

  initial begin
    m_q1 = 1'b0;
    m_q8 = 8'h00;
    #0.5;
    while (!done) begin
      if (!reset_n) begin
        m_q1 = 1'b0;
        m_q8 = 8'h00;
      end else if (clk) begin
        m_q1 = d1;
        m_q8 = d8;
      end
      check("model_q1",    {7'b0, q1},  {7'b0, m_q1});
      check("model_qbar1", {7'b0, qb1}, {7'b0, ~m_q1});
      check("model_q8",    q8,  m_q8);
      check("model_qbar8", qb8, ~m_q8);
      #1;
    end
  end

  // Directed stimulus with literal expectations.
  initial begin
    reset_n = 1'b0;
    d1      = 1'b1;
    d8      = 8'hFF;

    // Reset with clk toggling and d=1: outputs stay cleared.
    wait_until(7.5);
    check("rst_q_clk_high",    {7'b0, q1},  8'h00);
    check("rst_qbar_clk_high", {7'b0, qb1}, 8'h01);
    check("rst_q8",   q8,  8'h00);
    check("rst_qb8",  qb8, 8'hFF);
    wait_until(16); d1 = 1'b0;
    wait_until(17); d1 = 1'b1;
    wait_until(17.5);
    check("rst_dominates_enable", {7'b0, q1}, 8'h00);
    wait_until(22);
    d8 = 8'h00;

    // Release with clk low: stays 0 until the next rising edge.
    wait_until(32); reset_n = 1'b1;
    wait_until(33.5);
    check("release_clk_low", {7'b0, q1}, 8'h00);
    wait_until(35.5);
    check("open_edge_takes_d", {7'b0, q1}, 8'h01);

    // Transparency: q follows d within one high phase.
    wait_until(36); d1 = 1'b0;
    wait_until(36.5); check("transp_0", {7'b0, q1}, 8'h00);
    wait_until(37); d1 = 1'b1;
    wait_until(37.5); check("transp_1", {7'b0, q1}, 8'h01);
    check("transp_qbar", {7'b0, qb1}, 8'h00);
    wait_until(38); d1 = 1'b0;
    wait_until(38.5); check("transp_0b", {7'b0, q1}, 8'h00);
    wait_until(39); d1 = 1'b1;

    // Hold: d drops 2 ns after the fall, q holds until the next rise.
    wait_until(42); d1 = 1'b0;
    wait_until(42.5); check("hold_1", {7'b0, q1}, 8'h01);
    wait_until(45.5); check("hold_release", {7'b0, q1}, 8'h00);

    // Coincident closing edge: d falls exactly as clk falls.
    wait_until(46); d1 = 1'b1;
    @(negedge clk);
    d1 = 1'b0;
    wait_until(50.5); check("coincident_close", {7'b0, q1}, 8'h01);
    wait_until(54.5); check("coincident_hold", {7'b0, q1}, 8'h01);
    wait_until(55.5); check("coincident_reopen", {7'b0, q1}, 8'h00);

    // Reset mid-transparent, then release with clk high.
    wait_until(56); d1 = 1'b1;
    wait_until(56.5); check("pre_reset_q", {7'b0, q1}, 8'h01);
    wait_until(57); reset_n = 1'b0;
    wait_until(57.5); check("reset_mid_transp", {7'b0, q1}, 8'h00);
    check("reset_mid_transp_qbar", {7'b0, qb1}, 8'h01);
    wait_until(58); reset_n = 1'b1;
    wait_until(58.5); check("release_clk_high", {7'b0, q1}, 8'h01);

    // Reset during opaque phase loses the held value; release with clk low.
    wait_until(61); reset_n = 1'b0;
    wait_until(61.5); check("reset_opaque", {7'b0, q1}, 8'h00);
    wait_until(62); reset_n = 1'b1;
    wait_until(64.5); check("release_low_stays0", {7'b0, q1}, 8'h00);
    wait_until(65.5); check("release_low_then_rise", {7'b0, q1}, 8'h01);

    // 8-bit: capture A5, hold while d changes to 3C, then reopen.
    wait_until(66); d8 = 8'hA5;
    wait_until(66.5);
    check("w8_q_a5",    q8,  8'hA5);
    check("w8_qbar_5a", qb8, 8'h5A);
    wait_until(71); d8 = 8'h3C;
    wait_until(71.5); check("w8_hold_a5", q8, 8'hA5);
    wait_until(75.5); check("w8_reopen_3c", q8, 8'h3C);

    // Per-bit independence: flip individual bits while transparent.
    wait_until(76); d8 = 8'h3D;
    wait_until(76.5); check("w8_bit0", q8, 8'h3D);
    wait_until(77); d8 = 8'hBD;
    wait_until(77.5); check("w8_bit7", q8, 8'hBD);
    check("w8_bit7_qbar", qb8, 8'h42);
    wait_until(81); d8 = 8'h00;
    wait_until(81.5); check("w8_opaque_hold", q8, 8'hBD);

    wait_until(90);
    done = 1'b1;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
